// File: rtl/z80_waitgen.sv
// z80_waitgen: programmable Z80 wait-state generator placed downstream of the MMU.
// It decodes the MMU chip enables and the CPU strobes, then drives WAIT low for a
// programmable number of clocks per ROM, RAM or external I/O bus cycle.
// The wait counts live in a read/write I/O register at port $D2.
//
// Optional feature macro: WAITGEN_IO_EN
//   When defined, I/O cycles are waited per cfg[7:6] and that field is writable.
//   When undefined, only memory cycles are waited and cfg[7:6] is held at 0.
//
// Ports:
//   clk                       CPU clock (MMU sysclk), rising-edge
//   reset                     asynchronous, active-low reset
//   mreq iorq rd wr m1 rfsh   Z80 bus strobes, active-low
//   a07[7:0]                  CPU address bits 7:0
//   data[7:0]                 CPU data bus; driven with cfg during reads of $D2
//   romen ramen               MMU chip enables, active-low
//   wait_n                    to CPU WAIT, active-low, registered

module z80_waitgen #(
    parameter int unsigned ROM_WS_RST = 2,
    parameter int unsigned RAM_WS_RST = 0,
    parameter int unsigned IO_WS_RST  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mreq,
    input  logic       iorq,
    input  logic       rd,
    input  logic       wr,
    input  logic       m1,
    input  logic       rfsh,
    input  logic [7:0] a07,
    inout  logic [7:0] data,
    input  logic       romen,
    input  logic       ramen,
    output logic       wait_n
);

    localparam int unsigned CFG_W = 8;
    localparam int unsigned CNT_W = 3;
    localparam logic [7:0]  CFG_ADDR = 8'hD2;

`ifdef WAITGEN_IO_EN
    localparam logic [CFG_W-1:0] CFG_MASK = 8'hFF;
`else
    localparam logic [CFG_W-1:0] CFG_MASK = 8'h3F;
`endif

    localparam logic [CFG_W-1:0] CFG_RST =
        {2'(IO_WS_RST), 3'(RAM_WS_RST), 3'(ROM_WS_RST)} & CFG_MASK;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [CFG_W-1:0] cfg;
    logic             wr_seen;
    logic             cfg_sel;
    logic             mem_act;
    logic             io_act;
    logic             act;
    logic             prev_act;
    logic             start;
    logic [CNT_W-1:0] n_sel;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             wait_nx;

    // $D2 register decode and combinational read-back onto the CPU bus
    assign cfg_sel = !iorq && m1 && (a07 == CFG_ADDR);
    assign data    = (cfg_sel && !rd) ? cfg : 8'bz;

    // Refresh and interrupt-acknowledge cycles are excluded from act
    assign mem_act = !mreq && rfsh && (!romen || !ramen);
`ifdef WAITGEN_IO_EN
    assign io_act  = !iorq && m1;
`else
    assign io_act  = 1'b0;
`endif
    assign act     = mem_act || io_act;
    assign start   = act && !prev_act;

    // ROM enable wins over RAM enable; neither means an I/O cycle
    always_comb begin
        n_sel = {1'b0, cfg[7:6]};
        if (!romen) begin
            n_sel = cfg[2:0];
        end else if (!ramen) begin
            n_sel = cfg[5:3];
        end
    end

    // Config register: one load per write strobe, re-armed once wr is seen high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg     <= CFG_RST;
            wr_seen <= 1'b0;
        end else if (wr) begin
            wr_seen <= 1'b0;
        end else if (cfg_sel && !wr_seen) begin
            cfg     <= data & CFG_MASK;
            wr_seen <= 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            wait_n   <= 1'b1;
            prev_act <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            wait_n   <= wait_nx;
            prev_act <= act;
        end
    end

    // Next-state logic; cnt holds remaining waits minus one while in WAIT
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wait_nx  = wait_n;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (n_sel == '0) begin
                        wait_nx  = 1'b1;
                        state_nx = ST_DONE;
                    end else begin
                        cnt_nx   = n_sel - CNT_W'(1);
                        wait_nx  = 1'b0;
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!act) begin
                    // cycle vanished under us: release WAIT rather than hang the CPU
                    wait_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cnt == '0) begin
                    wait_nx  = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                wait_nx = 1'b1;
                if (!act) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                wait_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_z80_waitgen.sv
// Testbench for z80_waitgen: directed scenarios followed by randomized bus cycles.
// A stimulus process issues bus cycles and queues expected wait counts / read data;
// a monitor process measures WAIT pulses per cycle and checks against the queues.

module tb_z80_waitgen;

    logic       clk = 1'b0;
    logic       reset;
    logic       mreq, iorq, rd, wr, m1, rfsh, romen, ramen;
    logic [7:0] a07;
    wire  [7:0] data;
    logic       wait_n;
    logic       tb_drv;
    logic [7:0] tb_dout;

    assign data = tb_drv ? tb_dout : 8'bz;

    z80_waitgen dut (
        .clk    (clk),
        .reset  (reset),
        .mreq   (mreq),
        .iorq   (iorq),
        .rd     (rd),
        .wr     (wr),
        .m1     (m1),
        .rfsh   (rfsh),
        .a07    (a07),
        .data   (data),
        .romen  (romen),
        .ramen  (ramen),
        .wait_n (wait_n)
    );

    always #5 clk = ~clk;

`ifdef WAITGEN_IO_EN
    localparam bit         IO_EN = 1'b1;
    localparam logic [7:0] MASK  = 8'hFF;
`else
    localparam bit         IO_EN = 1'b0;
    localparam logic [7:0] MASK  = 8'h3F;
`endif
    localparam logic [7:0] RST_VAL = IO_EN ? 8'h42 : 8'h02;

    localparam int K_ROM     = 0;
    localparam int K_RAM     = 1;
    localparam int K_BOTH    = 2;
    localparam int K_NOEN    = 3;
    localparam int K_IORD    = 4;
    localparam int K_IORD_D2 = 5;
    localparam int K_IOWR_D2 = 6;
    localparam int K_RFSH    = 7;
    localparam int K_INTA    = 8;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_cfg;
    bit         cyc_active = 1'b0;
    int         exp_q[$];
    logic [7:0] exp_rd[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    // Reference: waits per cycle type from the modelled register fields
    function automatic int exp_waits(input int kind);
        int rom_f, ram_f, io_f;
        rom_f = int'(m_cfg) % 8;
        ram_f = (int'(m_cfg) / 8) % 8;
        io_f  = int'(m_cfg) / 64;
        case (kind)
            K_ROM, K_BOTH:                  return rom_f;
            K_RAM:                          return ram_f;
            K_IORD, K_IORD_D2, K_IOWR_D2:   return IO_EN ? io_f : 0;
            default:                        return 0;
        endcase
    endfunction

    task automatic idle_bus();
        mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1; rfsh = 1'b1;
        romen = 1'b1; ramen = 1'b1; tb_drv = 1'b0; tb_dout = 8'h00; a07 = 8'h00;
    endtask

    // Called #1 after a falling edge; returns #1 after a falling edge
    task automatic bus_cycle(input int kind, input logic [7:0] port,
                             input logic [7:0] wdata, input int extra);
        int n;
        n = exp_waits(kind);
        a07 = port;
        case (kind)
            K_ROM:     begin mreq = 1'b0; rd = 1'b0; romen = 1'b0; end
            K_RAM:     begin mreq = 1'b0; rd = 1'b0; ramen = 1'b0; end
            K_BOTH:    begin mreq = 1'b0; rd = 1'b0; romen = 1'b0; ramen = 1'b0; end
            K_NOEN:    begin mreq = 1'b0; wr = 1'b0; end
            K_IORD:    begin iorq = 1'b0; rd = 1'b0; if (port == 8'hD2) a07 = 8'hD3; end
            K_IORD_D2: begin iorq = 1'b0; rd = 1'b0; a07 = 8'hD2; exp_rd.push_back(m_cfg); end
            K_IOWR_D2: begin iorq = 1'b0; wr = 1'b0; a07 = 8'hD2; tb_drv = 1'b1; tb_dout = wdata; end
            K_RFSH:    begin mreq = 1'b0; rfsh = 1'b0; romen = 1'b0; end
            default:   begin iorq = 1'b0; m1 = 1'b0; end
        endcase
        exp_q.push_back(n);
        cyc_active = 1'b1;
        @(negedge clk);
        #1;
        // changing data after the load edge exposes any repeated load
        if (kind == K_IOWR_D2) tb_dout = ~wdata;
        repeat (n + extra) @(negedge clk);
        #1;
        idle_bus();
        cyc_active = 1'b0;
        if (kind == K_IOWR_D2) m_cfg = wdata & MASK;
        @(negedge clk);
        #1;
    endtask

    // Monitor: measures the WAIT pulse of each cycle and checks $D2 read data
    initial begin
        int  lows, first, last, idx, measured, exp_n;
        bit  prev_active, rd_done;
        logic [7:0] er;
        lows = 0; first = 0; last = 0; idx = 0; prev_active = 1'b0; rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc_active) begin
                idx++;
                if (wait_n == 1'b0) begin
                    lows++;
                    if (first == 0) first = idx;
                    last = idx;
                end
                if (!rd && !iorq && m1 && a07 == 8'hD2 && !rd_done) begin
                    rd_done = 1'b1;
                    if (exp_rd.size() == 0) begin
                        chk("rd_queue_empty", 1, 0);
                    end else begin
                        er = exp_rd.pop_front();
                        chk("cfg_readback", int'(data), int'(er));
                    end
                end
            end else begin
                if (prev_active) begin
                    measured = (lows == 0) ? 0 : ((last - first + 1 == lows) ? lows : -1);
                    if (exp_q.size() == 0) begin
                        chk("wait_queue_empty", 1, 0);
                    end else begin
                        exp_n = exp_q.pop_front();
                        chk("wait_cycles", measured, exp_n);
                        if (exp_n > 0) chk("wait_first_edge", first, 1);
                    end
                end
                chk("wait_idle_high", int'(wait_n), 1);
                lows = 0; first = 0; last = 0; idx = 0; rd_done = 1'b0;
            end
            prev_active = cyc_active;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, extra;
        logic [7:0] port, wd;
        idle_bus();
        reset = 1'b0;
        m_cfg = RST_VAL;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_wait_n", int'(wait_n), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;

        bus_cycle(K_IORD_D2, 8'hD2, 8'h00, 1);
        bus_cycle(K_ROM, 8'h10, 8'h00, 0);

        bus_cycle(K_IOWR_D2, 8'hD2, 8'h1B, 1);
        bus_cycle(K_RAM, 8'h20, 8'h00, 1);
        bus_cycle(K_ROM, 8'h30, 8'h00, 2);
        bus_cycle(K_IORD, 8'hD4, 8'h00, 1);

        bus_cycle(K_RFSH, 8'h40, 8'h00, 2);
        bus_cycle(K_INTA, 8'h50, 8'h00, 2);

        // ROM waits 7, then reset in the middle of the wait window
        bus_cycle(K_IOWR_D2, 8'hD2, 8'h47, 0);
        romen = 1'b0; mreq = 1'b0; rd = 1'b0;
        exp_q.push_back(3);
        cyc_active = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_release", int'(wait_n), 1);
        idle_bus();
        cyc_active = 1'b0;
        m_cfg = RST_VAL;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        bus_cycle(K_IORD_D2, 8'hD2, 8'h00, 0);
        bus_cycle(K_ROM, 8'h00, 8'h00, 1);

        // wr held across 4 edges: exactly one load from the first edge
        bus_cycle(K_IOWR_D2, 8'hD2, 8'hFF, 3 - exp_waits(K_IOWR_D2));
        bus_cycle(K_IORD_D2, 8'hD2, 8'h00, 1);

        for (int i = 0; i < 150; i++) begin
            kind  = int'($urandom_range(0, 8));
            port  = 8'($urandom_range(0, 255));
            wd    = 8'($urandom_range(0, 255));
            extra = int'($urandom_range(0, 2));
            bus_cycle(kind, port, wd, extra);
        end

        repeat (3) @(negedge clk);
        chk("wait_queue_drained", exp_q.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
